// File: rtl/instr_fetch_unit.sv
// Instruction fetch stage: fetch PC, ordered memory reads, in-order prefetch queue, redirect flush.
// Latency: request fire at N, response at N+1 or later, instruction visible at response+1 (no bypass).
// Backpressure: instr_ready holds the queue head; queued plus outstanding reads are capped at DEPTH,
// so mem_req drops when the queue cannot absorb more responses.
//
// Ports:
//   clk_i, reset_i                    clock, synchronous active-high reset
//   mem_req_o/mem_addr_o/mem_ack_i    read request handshake (fire = req & ack)
//   mem_rvalid_i/mem_rdata_i          in-order read responses
//   instr_valid_o/instr_o/instr_pc_o  queue head presented to the datapath
//   instr_ready_i                     datapath consumes the head this cycle
//   redirect_i/redirect_pc_i          taken branch or jump: flush and refetch
//   halt_i                            level; blocks new requests only

// Generic in-order FIFO with a synchronous flush.
// Latency: a pushed word is at the head one cycle after the push (when the FIFO was empty).
// Backpressure: none internally; the caller must not push when full or pop when empty.
module ifu_fifo #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 4,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             flush_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] push_dat_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] head_dat_o,
  output logic [CNT_W-1:0] count_o
);

  localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;

  // Flush wins over a concurrent push or pop: both are dropped.
  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push_i) begin
        wr_ptr_d = wr_ptr_q + PTR_ONE;
      end
      if (pop_i) begin
        rd_ptr_d = rd_ptr_q + PTR_ONE;
      end
      case ({push_i, pop_i})
        2'b10:   count_d = count_q + CNT_ONE;
        2'b01:   count_d = count_q - CNT_ONE;
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: the count qualifies every read of it.
  always_ff @(posedge clk_i) begin
    if (push_i && !flush_i) begin
      mem_q[wr_ptr_q] <= push_dat_i;
    end
  end

  assign head_dat_o = mem_q[rd_ptr_q];
  assign count_o    = count_q;

endmodule

module instr_fetch_unit #(
  parameter int DEPTH = 4
) (
  input  logic        clk_i,
  input  logic        reset_i,
  output logic        mem_req_o,
  output logic [15:0] mem_addr_o,
  input  logic        mem_ack_i,
  input  logic        mem_rvalid_i,
  input  logic [15:0] mem_rdata_i,
  output logic        instr_valid_o,
  output logic [15:0] instr_o,
  output logic [15:0] instr_pc_o,
  input  logic        instr_ready_i,
  input  logic        redirect_i,
  input  logic [15:0] redirect_pc_i,
  input  logic        halt_i
);

  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic [15:0]      fetch_pc_q, fetch_pc_d;
  logic [15:0]      head_pc_q, head_pc_d;
  logic [CNT_W-1:0] outstanding_q, outstanding_d;
  logic [CNT_W-1:0] drop_q, drop_d;

  logic [CNT_W-1:0] q_count;
  logic [15:0]      q_head;
  logic [CNT_W:0]   occupancy;
  logic [15:0]      target_pc;
  logic             fire;
  logic             rsp_accept;
  logic             rsp_discard;
  logic             push;
  logic             pop;
  logic             unused_redirect_lsb;

  // Fetch is halfword aligned; the low bit of the target is meaningless.
  assign target_pc           = {redirect_pc_i[15:1], 1'b0};
  assign unused_redirect_lsb = redirect_pc_i[0];

  // Every outstanding read owns a queue slot, so a response can never find
  // the queue full. Reads that will be dropped still hold their slot; that
  // is conservative and only costs a little bandwidth right after a redirect.
  assign occupancy = {1'b0, q_count} + {1'b0, outstanding_q};
  assign mem_req_o = ~reset_i & ~halt_i & ~redirect_i & (occupancy < {1'b0, DEPTH_C});
  assign mem_addr_o = fetch_pc_q;
  assign fire       = mem_req_o & mem_ack_i;

  // A response with nothing outstanding belongs to a read issued before a
  // reset; it is ignored so the counters cannot underflow.
  assign rsp_accept  = mem_rvalid_i & (outstanding_q != '0);
  // Responses are ordered, so while drop is non-zero the arriving word is
  // one of the pre-redirect reads. A response in the redirect cycle itself is
  // also stale.
  assign rsp_discard = (drop_q != '0) | redirect_i;
  assign push        = rsp_accept & ~rsp_discard;

  assign instr_valid_o = (q_count != '0);
  assign pop           = instr_valid_o & instr_ready_i & ~redirect_i;
  assign instr_o       = instr_valid_o ? q_head : 16'h0000;
  assign instr_pc_o    = head_pc_q;

  ifu_fifo #(
    .WIDTH (16),
    .DEPTH (DEPTH)
  ) u_queue (
    .clk_i      (clk_i),
    .reset_i    (reset_i),
    .flush_i    (redirect_i),
    .push_i     (push),
    .push_dat_i (mem_rdata_i),
    .pop_i      (pop),
    .head_dat_o (q_head),
    .count_o    (q_count)
  );

  always_comb begin
    fetch_pc_d    = fetch_pc_q;
    head_pc_d     = head_pc_q;
    drop_d        = drop_q;
    outstanding_d = outstanding_q;
    if (fire) begin
      outstanding_d = outstanding_d + CNT_ONE;
    end
    if (rsp_accept) begin
      outstanding_d = outstanding_d - CNT_ONE;
    end

    if (redirect_i) begin
      fetch_pc_d = target_pc;
      head_pc_d  = target_pc;
      // No request fires in a redirect cycle, so every read still in flight
      // after this edge predates the redirect and must be thrown away.
      drop_d     = outstanding_d;
    end else begin
      if (fire) begin
        fetch_pc_d = fetch_pc_q + 16'd2;
      end
      if (pop) begin
        head_pc_d = head_pc_q + 16'd2;
      end
      if (rsp_accept && (drop_q != '0)) begin
        drop_d = drop_q - CNT_ONE;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      fetch_pc_q    <= 16'h0000;
      head_pc_q     <= 16'h0000;
      outstanding_q <= '0;
      drop_q        <= '0;
    end else begin
      fetch_pc_q    <= fetch_pc_d;
      head_pc_q     <= head_pc_d;
      outstanding_q <= outstanding_d;
      drop_q        <= drop_d;
    end
  end

  // The request cap must keep a kept response from ever meeting a full queue.
  a_no_push_when_full: assert property (@(posedge clk_i) disable iff (reset_i)
    !(push && (q_count == DEPTH_C)));

  // Dropped reads are a subset of the outstanding ones.
  a_drop_le_outstanding: assert property (@(posedge clk_i) disable iff (reset_i)
    drop_q <= outstanding_q);

endmodule
